iob_cache_read_channel: RTL and testbench

IOB_CACHE_READ_CHANNEL -- requirements
Module: iob_cache_read_channel

---
 rtl/iob_cache_read_channel.sv | 114 +++++++++++
 tb/tb_iob_cache_read_channel.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_read_channel.sv
// -----------------------------------------------------------------------------
// iob_cache_read_channel
//
// Cache line refill engine. On a miss the requester raises replace_valid_i with
// the line address on addr_i. The block then issues back-end read requests, one
// back-end word at a time, and streams each returned word into the cache line
// buffer through read_valid_o / read_addr_o / read_data_o. After the last word
// it spends one cycle in END before returning to IDLE.
//
// Ports
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   replace_valid_i       refill request (sampled in IDLE only)
//   addr_i                line address of the miss, held until replace_o falls
//   replace_o             refill in progress (state != IDLE)
//   read_valid_o          line buffer write enable (READ and be_ack_i)
//   read_addr_o           back-end word index within the line
//   read_data_o           refill data (be_rdata_i passed straight through)
//   be_addr_o             back-end byte address {addr_i, word_cnt, 0...}
//   be_valid_o            back-end read request (state == READ)
//   be_ack_i, be_rdata_i  back-end data valid and read data
// -----------------------------------------------------------------------------
module iob_cache_read_channel #(
  parameter int FE_ADDR_W     = 24,
  parameter int FE_DATA_W     = 32,
  parameter int BE_ADDR_W     = 24,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 2,
  localparam int BE_NBYTES_W  = $clog2(BE_DATA_W / 8),
  localparam int LINE2BE_W    = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int RADDR_W      = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  input  logic                                       replace_valid_i,
  input  logic [FE_ADDR_W-1:BE_NBYTES_W+LINE2BE_W]   addr_i,
  output logic                                       replace_o,
  output logic                                       read_valid_o,
  output logic [RADDR_W-1:0]                         read_addr_o,
  output logic [BE_DATA_W-1:0]                       read_data_o,
  output logic [BE_ADDR_W-1:0]                       be_addr_o,
  output logic                                       be_valid_o,
  input  logic                                       be_ack_i,
  input  logic [BE_DATA_W-1:0]                       be_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    END  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_word;
  logic [FE_ADDR_W-1:0] be_addr_full;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Acks outside READ and requests outside IDLE are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (replace_valid_i)       state_d = READ;
      READ:    if (be_ack_i && last_word) state_d = END;
      END:                                state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word counter. With a back-end word as wide as the whole line there is
  // nothing to count: the line is a single word and the first ack finishes it.
  // ---------------------------------------------------------------------------
  generate
    if (LINE2BE_W > 0) begin : g_cnt
      logic [LINE2BE_W-1:0] word_cnt;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
          word_cnt <= '0;
        else if (state_q == IDLE && replace_valid_i)
          word_cnt <= '0;
        else if (state_q == READ && be_ack_i)
          word_cnt <= word_cnt + LINE2BE_W'(1);   // wraps to 0 after last word
      end

      assign last_word    = &word_cnt;
      assign read_addr_o  = word_cnt;
      assign be_addr_full = {addr_i, word_cnt, {BE_NBYTES_W{1'b0}}};
    end else begin : g_nocnt
      assign last_word    = 1'b1;
      assign read_addr_o  = '0;
      assign be_addr_full = {addr_i, {BE_NBYTES_W{1'b0}}};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign replace_o    = (state_q != IDLE);
  assign be_valid_o   = (state_q == READ);
  assign read_valid_o = (state_q == READ) && be_ack_i;
  assign read_data_o  = be_rdata_i;
  // Unsigned cast zero-extends or truncates to the back-end address width.
  assign be_addr_o    = BE_ADDR_W'(be_addr_full);

endmodule

// File: tb/tb_iob_cache_read_channel.sv
// -----------------------------------------------------------------------------
// Directed bench for iob_cache_read_channel. Default instance (32-bit back end,
// four words per line) plus a 128-bit back-end instance (single-word line).
// -----------------------------------------------------------------------------
module tb_iob_cache_read_channel;

  logic        clk;
  logic        rst_n;

  // default instance
  logic        req;
  logic [19:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        replace, rvalid, bvalid;
  logic [1:0]  raddr;
  logic [31:0] rdata_o;
  logic [23:0] baddr;

  // wide instance
  logic         w_req;
  logic [19:0]  w_addr;
  logic         w_ack;
  logic [127:0] w_rdata;
  logic         w_replace, w_rvalid, w_bvalid;
  logic [0:0]   w_raddr;
  logic [127:0] w_rdata_o;
  logic [23:0]  w_baddr;

  int pass_cnt = 0;
  int total    = 0;

  iob_cache_read_channel u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .replace_valid_i(req), .addr_i(addr),
    .replace_o(replace), .read_valid_o(rvalid), .read_addr_o(raddr),
    .read_data_o(rdata_o), .be_addr_o(baddr), .be_valid_o(bvalid),
    .be_ack_i(ack), .be_rdata_i(rdata)
  );

  iob_cache_read_channel #(.BE_DATA_W(128)) u_wide (
    .clk_i(clk), .reset_n_i(rst_n), .replace_valid_i(w_req), .addr_i(w_addr),
    .replace_o(w_replace), .read_valid_o(w_rvalid), .read_addr_o(w_raddr),
    .read_data_o(w_rdata_o), .be_addr_o(w_baddr), .be_valid_o(w_bvalid),
    .be_ack_i(w_ack), .be_rdata_i(w_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [4:0] got;
    ack = 1'b1;
    #1;
    got = {replace, bvalid, rvalid, raddr};
    total++;
    if (got !== 5'b0) $display("FAIL reset_outputs got=%b exp=00000", got);
    else pass_cnt++;
    step();
    step();
    got = {replace, bvalid, rvalid, raddr};
    total++;
    if (got !== 5'b0) $display("FAIL reset_held got=%b exp=00000", got);
    else pass_cnt++;
    rst_n = 1'b1;
    ack   = 1'b0;
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic();
    logic [59:0] got, exp;
    addr = 20'h00012;
    req  = 1'b1;
    ack  = 1'b1;
    #1;
    total++;
    if (replace !== 1'b0) $display("FAIL basic_pre replace=%b exp=0", replace);
    else pass_cnt++;
    step();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdata = 32'hA000_0000 + 32'(i);
      #1;
      got = {replace, bvalid, rvalid, raddr, baddr, rdata_o};
      exp = {1'b1, 1'b1, 1'b1, 2'(i), 24'h000120 + 24'(4 * i), 32'hA000_0000 + 32'(i)};
      total++;
      if (got !== exp) $display("FAIL basic_word%0d got=%h exp=%h", i, got, exp);
      else pass_cnt++;
      step();
    end
    #1;
    total++;
    if ({replace, bvalid, rvalid} !== 3'b100)
      $display("FAIL basic_end got=%b exp=100", {replace, bvalid, rvalid});
    else pass_cnt++;
    ack = 1'b0;
    step();
    total++;
    if ({replace, bvalid, rvalid} !== 3'b000)
      $display("FAIL basic_idle got=%b exp=000", {replace, bvalid, rvalid});
    else pass_cnt++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall();
    int n = 0;
    int bad = 0;
    req = 1'b1;
    step();
    req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ack = (k % 3 == 2);
      #1;
      if (bvalid !== 1'b1 || baddr !== 24'h000120 + 24'(4 * n) || rvalid !== ack ||
          (ack && raddr !== 2'(n))) begin
        bad++;
        $display("FAIL stall_cycle%0d bvalid=%b baddr=%h rvalid=%b raddr=%0d exp_addr=%h exp_rv=%b",
                 k, bvalid, baddr, rvalid, raddr, 24'h000120 + 24'(4 * n), ack);
      end
      if (rvalid === 1'b1) n++;
      step();
    end
    ack = 1'b0;
    total++;
    if (bad != 0) $display("FAIL stall_hold bad_cycles=%0d exp=0", bad);
    else pass_cnt++;
    total++;
    if (n != 4) $display("FAIL stall_pulses got=%0d exp=4", n);
    else pass_cnt++;
    #1;
    total++;
    if ({replace, bvalid} !== 2'b10) $display("FAIL stall_end got=%b exp=10", {replace, bvalid});
    else pass_cnt++;
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    int stray = 0;
    int guard = 0;
    req = 1'b1;
    step();
    req = 1'b0;
    ack = 1'b1;
    step();
    step();                // two words accepted
    rst_n = 1'b0;          // asserted mid-cycle, no clock edge
    #1;
    total++;
    if ({replace, bvalid, rvalid} !== 3'b000)
      $display("FAIL rstmid_async got=%b exp=000", {replace, bvalid, rvalid});
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (rvalid !== 1'b0 || replace !== 1'b0) stray++;
      step();
    end
    total++;
    if (stray != 0) $display("FAIL rstmid_after stray=%0d exp=0", stray);
    else pass_cnt++;
    req = 1'b1;
    step();
    req = 1'b0;
    #1;
    total++;
    if ({bvalid, baddr, raddr} !== {1'b1, 24'h000120, 2'd0})
      $display("FAIL rstmid_restart bvalid=%b baddr=%h raddr=%0d exp=1 000120 0", bvalid, baddr, raddr);
    else pass_cnt++;
    while (replace === 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    total++;
    if (replace !== 1'b0) $display("FAIL rstmid_timeout replace=%b exp=0", replace);
    else pass_cnt++;
    ack = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stray();
    int bad = 0;
    int n = 0;
    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if ({replace, bvalid, rvalid} !== 3'b000) bad++;
      step();
    end
    total++;
    if (bad != 0) $display("FAIL stray_idle_ack bad=%0d exp=0", bad);
    else pass_cnt++;
    req = 1'b1;
    step();
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req = (k == 1);      // stray request mid-burst
      #1;
      if (rvalid === 1'b1 && raddr === 2'(n)) n++;
      step();
    end
    req = 1'b0;
    total++;
    if (n != 4) $display("FAIL stray_words got=%0d exp=4", n);
    else pass_cnt++;
    #1;
    total++;
    if ({replace, bvalid} !== 2'b10) $display("FAIL stray_end got=%b exp=10", {replace, bvalid});
    else pass_cnt++;
    step();
    step();
    total++;
    if (replace !== 1'b0) $display("FAIL stray_no_restart replace=%b exp=0", replace);
    else pass_cnt++;
    ack = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_held();
    int guard = 0;
    req = 1'b1;
    ack = 1'b1;
    step();
    for (int k = 0; k < 4; k++) step();
    #1;
    total++;
    if ({replace, bvalid} !== 2'b10) $display("FAIL held_end got=%b exp=10", {replace, bvalid});
    else pass_cnt++;
    step();
    total++;
    if ({replace, bvalid} !== 2'b00) $display("FAIL held_idle got=%b exp=00", {replace, bvalid});
    else pass_cnt++;
    step();
    total++;
    if ({replace, bvalid, baddr, raddr} !== {1'b1, 1'b1, 24'h000120, 2'd0})
      $display("FAIL held_restart replace=%b bvalid=%b baddr=%h raddr=%0d exp=1 1 000120 0",
               replace, bvalid, baddr, raddr);
    else pass_cnt++;
    req = 1'b0;
    while (replace === 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    total++;
    if (replace !== 1'b0) $display("FAIL held_timeout replace=%b exp=0", replace);
    else pass_cnt++;
    ack = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wide();
    w_addr  = 20'h00012;
    w_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    w_req   = 1'b1;
    step();
    w_req = 1'b0;
    w_ack = 1'b1;
    #1;
    total++;
    if ({w_replace, w_bvalid, w_rvalid, w_raddr, w_baddr} !== {1'b1, 1'b1, 1'b1, 1'b0, 24'h000120})
      $display("FAIL wide_read got=%b%b%b raddr=%0d baddr=%h exp=111 0 000120",
               w_replace, w_bvalid, w_rvalid, w_raddr, w_baddr);
    else pass_cnt++;
    total++;
    if (w_rdata_o !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D)
      $display("FAIL wide_data got=%h", w_rdata_o);
    else pass_cnt++;
    step();
    total++;
    if ({w_replace, w_bvalid, w_rvalid} !== 3'b100)
      $display("FAIL wide_end got=%b exp=100", {w_replace, w_bvalid, w_rvalid});
    else pass_cnt++;
    step();
    total++;
    if (w_replace !== 1'b0) $display("FAIL wide_idle replace=%b exp=0", w_replace);
    else pass_cnt++;
    w_ack = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    req = 1'b0; addr = 20'h00012; ack = 1'b0; rdata = 32'h0;
    w_req = 1'b0; w_addr = 20'h00012; w_ack = 1'b0; w_rdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_stray();
    test_held();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
